// File: rtl/fetch_buf_reader_if.sv
// Handshake bundle between the fetch side (master) and the buffer reader (slave).
// Carries line loads, flush redirect, decoder consume and the presented window.
interface fetch_buf_reader_if #(
    parameter int LINE_BYTES = 16,
    parameter int PTR_W      = 5
);
    logic [1:0]              ld_buf;
    logic [8*LINE_BYTES-1:0] line_data;
    logic                    flush;
    logic [PTR_W-2:0]        flush_off;
    logic                    dec_ack;
    logic [3:0]              dec_len;
    logic [8*LINE_BYTES-1:0] win_data;
    logic                    win_valid;
    logic [1:0]              rel;
    logic [1:0]              occ;
    logic [PTR_W-1:0]        ptr;

    modport master (
        output ld_buf, line_data, flush, flush_off, dec_ack, dec_len,
        input  win_data, win_valid, rel, occ, ptr
    );

    modport slave (
        input  ld_buf, line_data, flush, flush_off, dec_ack, dec_len,
        output win_data, win_valid, rel, occ, ptr
    );
endinterface

// File: rtl/fetch_buf_reader.sv
// Two-half 32-byte circular fetch buffer: presents a 16-byte window at the decode
// pointer, advances it per decoded instruction and pulses rel when a half drains.
module fetch_buf_reader #(
    parameter int LINE_BYTES = 16,
    parameter int PTR_W      = 5
) (
    input logic               clk,
    input logic               rst_n,
    fetch_buf_reader_if.slave bus
);
    localparam int LINE_W = 8 * LINE_BYTES;

    logic [1:0][LINE_W-1:0] r_buf;
    logic [1:0]             r_occ;
    logic [1:0]             r_rel;
    logic [PTR_W-1:0]       r_ptr;

    logic                   w_half;
    logic [PTR_W-2:0]       w_off;
    logic                   w_win_valid;
    logic                   w_consume;
    logic [PTR_W-1:0]       w_np;
    logic                   w_cross;
    logic [1:0]             w_occ_nxt;
    logic [1:0]             w_rel_nxt;
    logic [4*LINE_W-1:0]    w_dbl;
    logic [PTR_W+3:0]       w_shift;

    assign w_half      = r_ptr[PTR_W-1];
    assign w_off       = r_ptr[PTR_W-2:0];
    assign w_win_valid = (r_occ[w_half] && (w_off == '0)) || (&r_occ);
    assign w_consume   = bus.dec_ack && w_win_valid && (bus.dec_len != 4'd0);
    assign w_np        = r_ptr + {1'b0, bus.dec_len};
    assign w_cross     = w_consume && (w_np[PTR_W-1] != w_half);

    // Doubling the buffer turns the mod-32 byte rotate into a single part-select.
    assign w_dbl   = {r_buf, r_buf};
    assign w_shift = {1'b0, r_ptr, 3'b000};

    always_comb begin
        w_occ_nxt = r_occ;
        w_rel_nxt = 2'b00;
        if (w_cross) begin
            w_occ_nxt[w_half] = 1'b0;
            w_rel_nxt[w_half] = 1'b1;
        end
        // A load into a half drained on the same edge wins over the drain.
        w_occ_nxt = w_occ_nxt | bus.ld_buf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
            r_occ <= 2'b00;
            r_rel <= 2'b00;
            r_ptr <= '0;
        end else if (bus.flush) begin
            r_occ <= 2'b00;
            r_rel <= 2'b00;
            r_ptr <= {1'b0, bus.flush_off};
        end else begin
            r_occ <= w_occ_nxt;
            r_rel <= w_rel_nxt;
            if (w_consume) begin
                r_ptr <= w_np;
            end
            if (bus.ld_buf[0]) begin
                r_buf[0] <= bus.line_data;
            end
            if (bus.ld_buf[1]) begin
                r_buf[1] <= bus.line_data;
            end
        end
    end

    assign bus.win_data  = w_dbl[w_shift +: LINE_W];
    assign bus.win_valid = w_win_valid;
    assign bus.rel       = r_rel;
    assign bus.occ       = r_occ;
    assign bus.ptr       = r_ptr;
endmodule

// File: tb/tb_fetch_buf_reader.sv
// Directed bench for fetch_buf_reader: a byte-array reference model checked every
// cycle, plus hand-computed literal expectations along each scenario.
module tb_fetch_buf_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_buf_reader_if #(.LINE_BYTES(16), .PTR_W(5)) bus ();

    fetch_buf_reader #(.LINE_BYTES(16), .PTR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: a plain 32-byte array, per-half valid flags, integer pointer.
    logic [7:0] mbuf [32];
    logic [1:0] mocc = 2'b00;
    logic [1:0] mrel = 2'b00;
    int         mptr = 0;
    logic [1:0] m_nocc;
    int         m_np;
    int         m_relh;
    bit         m_take;

    initial for (int j = 0; j < 32; j++) mbuf[j] = 8'h00;

    function automatic bit m_valid();
        for (int k = 0; k < 16; k++)
            if (!mocc[((mptr + k) % 32) / 16]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [127:0] m_win();
        logic [127:0] w;
        for (int k = 0; k < 16; k++) w[8*k +: 8] = mbuf[(mptr + k) % 32];
        return w;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 32; j++) mbuf[j] = 8'h00;
            mocc = 2'b00;
            mrel = 2'b00;
            mptr = 0;
        end else if (bus.flush) begin
            mocc = 2'b00;
            mrel = 2'b00;
            mptr = int'(bus.flush_off);
        end else begin
            m_nocc = mocc;
            mrel   = 2'b00;
            m_relh = -1;
            m_take = m_valid() && bus.dec_ack && (bus.dec_len != 0);
            if (m_take) begin
                m_np = (mptr + int'(bus.dec_len)) % 32;
                if (m_np / 16 != mptr / 16) begin
                    m_relh = mptr / 16;
                    m_nocc[m_relh] = 1'b0;
                    mrel[m_relh] = 1'b1;
                end
                mptr = m_np;
            end
            for (int i = 0; i < 2; i++) begin
                if (bus.ld_buf[i]) begin
                    n_cmp++;
                    if (mocc[i] && m_relh != i) begin
                        n_err++;
                        $display("FAIL proto_overwrite: load into occupied half %0d at %0t", i, $time);
                    end
                    for (int b = 0; b < 16; b++) mbuf[16*i + b] = bus.line_data[8*b +: 8];
                    m_nocc[i] = 1'b1;
                end
            end
            mocc = m_nocc;
        end
    end

    always @(negedge clk) begin
        chk("cyc_win_valid", bus.win_valid, m_valid());
        chk("cyc_win_data", bus.win_data, m_win());
        chk("cyc_rel", bus.rel, mrel);
        chk("cyc_occ", bus.occ, mocc);
        chk("cyc_ptr", bus.ptr, mptr[4:0]);
    end

    task automatic idle_in();
        bus.ld_buf    = 2'b00;
        bus.line_data = '0;
        bus.flush     = 1'b0;
        bus.flush_off = 4'd0;
        bus.dec_ack   = 1'b0;
        bus.dec_len   = 4'd0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [127:0] line_of(input logic [7:0] base);
        logic [127:0] l;
        for (int b = 0; b < 16; b++) l[8*b +: 8] = base + 8'(b);
        return l;
    endfunction

    task automatic do_flush(input logic [3:0] off);
        bus.flush = 1'b1; bus.flush_off = off;
        tick(); idle_in();
    endtask

    task automatic load(input logic [1:0] mask, input logic [7:0] base);
        bus.ld_buf = mask; bus.line_data = line_of(base);
        tick(); idle_in();
    endtask

    task automatic consume(input logic [3:0] len);
        bus.dec_ack = 1'b1; bus.dec_len = len;
        tick(); idle_in();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset / idle
        repeat (10) begin
            tick();
            chk("idle_occ", bus.occ, 2'b00);
            chk("idle_ptr", bus.ptr, 5'd0);
            chk("idle_valid", bus.win_valid, 1'b0);
            chk("idle_rel", bus.rel, 2'b00);
            chk("idle_data", bus.win_data, 128'd0);
        end

        // Aligned fill and consume
        do_flush(4'd0);
        load(2'b01, 8'h00);
        chk("fill_valid", bus.win_valid, 1'b1);
        chk("fill_b0", bus.win_data[7:0], 8'h00);
        consume(4'd3);
        chk("c3_ptr", bus.ptr, 5'd3);
        chk("c3_valid", bus.win_valid, 1'b0);
        load(2'b10, 8'h10);
        chk("h1_valid", bus.win_valid, 1'b1);
        chk("h1_b0", bus.win_data[7:0], 8'h03);
        chk("h1_b15", bus.win_data[127:120], 8'h12);

        // Boundary release
        consume(4'd11);
        chk("to14_ptr", bus.ptr, 5'd14);
        chk("to14_rel", bus.rel, 2'b00);
        consume(4'd5);
        chk("rel_ptr", bus.ptr, 5'd19);
        chk("rel_occ", bus.occ, 2'b10);
        chk("rel_pulse", bus.rel, 2'b01);
        chk("model_ptr", mptr, 19);
        tick();
        chk("rel_clear", bus.rel, 2'b00);
        chk("rel_valid", bus.win_valid, 1'b0);
        load(2'b01, 8'h20);
        chk("reload_valid", bus.win_valid, 1'b1);
        chk("reload_b0", bus.win_data[7:0], 8'h13);

        // Wrap-around
        consume(4'd11);
        chk("to30_ptr", bus.ptr, 5'd30);
        consume(4'd4);
        chk("wrap_ptr", bus.ptr, 5'd2);
        chk("wrap_rel", bus.rel, 2'b10);
        chk("wrap_occ", bus.occ, 2'b01);
        load(2'b10, 8'h30);
        chk("wrap_b0", bus.win_data[7:0], 8'h22);
        chk("wrap_valid", bus.win_valid, 1'b1);

        // Same-cycle release and reload of half 0
        bus.dec_ack = 1'b1; bus.dec_len = 4'd15;
        bus.ld_buf = 2'b01; bus.line_data = line_of(8'h40);
        tick(); idle_in();
        chk("same_rel", bus.rel, 2'b01);
        chk("same_occ", bus.occ, 2'b11);
        chk("same_ptr", bus.ptr, 5'd17);
        chk("same_b15", bus.win_data[127:120], 8'h40);

        // Flush priority
        bus.flush = 1'b1; bus.flush_off = 4'd9;
        bus.dec_ack = 1'b1; bus.dec_len = 4'd3;
        bus.ld_buf = 2'b10; bus.line_data = line_of(8'hA0);
        tick(); idle_in();
        chk("fl_occ", bus.occ, 2'b00);
        chk("fl_ptr", bus.ptr, 5'd9);
        chk("fl_rel", bus.rel, 2'b00);
        chk("fl_valid", bus.win_valid, 1'b0);
        load(2'b01, 8'h50);
        chk("fl_h0_valid", bus.win_valid, 1'b0);
        consume(4'd2);
        chk("ign_ptr", bus.ptr, 5'd9);
        load(2'b10, 8'h60);
        chk("fl_both_valid", bus.win_valid, 1'b1);
        chk("fl_b0", bus.win_data[7:0], 8'h59);
        consume(4'd0);
        chk("len0_ptr", bus.ptr, 5'd9);

        // Reset mid-operation, coinciding with a presented consume
        #2;
        bus.dec_ack = 1'b1; bus.dec_len = 4'd10;
        rst_n = 1'b0;
        #1;
        chk("rst_occ", bus.occ, 2'b00);
        chk("rst_ptr", bus.ptr, 5'd0);
        chk("rst_rel", bus.rel, 2'b00);
        chk("rst_valid", bus.win_valid, 1'b0);
        chk("rst_data", bus.win_data, 128'd0);
        tick();
        chk("rst_hold_rel", bus.rel, 2'b00);
        idle_in();
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_rel", bus.rel, 2'b00);
        chk("post_rst_ptr", bus.ptr, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_buf_reader.md
# fetch_buf_reader

Consumer side of the two-half instruction fetch buffer. The fetch FSM writes 16-byte lines into half 0 or half 1 via `ld_buf`. This block holds both halves as a 32-byte circular byte queue and presents a byte-aligned 16-byte window at the current decode pointer. It advances that pointer by each decoded instruction length and returns a one-cycle release pulse whenever a half is fully drained, so the fetch side can refill it.

## Interface
Parameters:
- `LINE_BYTES`, 16: bytes per buffer half. Fixed; other values are unsupported.
- `PTR_W`, 5: pointer width, log2(2*LINE_BYTES).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `ld_buf`  in  2  per-half load strobe. Bit i writes `line_data` into half i.
- `line_data`  in  128  fetched line. Byte 0 is in [7:0].
- `flush`  in  1  redirect: discard buffer contents and reload the pointer.
- `flush_off`  in  4  byte offset of the new EIP within its line.
- `dec_ack`  in  1  decoder consumed the instruction at the window head.
- `dec_len`  in  4  length of the consumed instruction, 1..15.
- `win_data`  out  128  bytes at ptr..ptr+15 (mod 32). Byte 0 is in [7:0].
- `win_valid`  out  1  all 16 window bytes are valid.
- `rel`  out  2  registered one-cycle pulse: half i drained.
- `occ`  out  2  per-half valid bits (registered).
- `ptr`  out  5  current decode pointer. Bit 4 selects the half.

## Operation
State:
- `buf[0:31]` bytes
- `occ[1:0]`
- `ptr[4:0]`
- `rel[1:0]`

Window availability:
- h = ptr[4], o = ptr[3:0].
- `win_valid` = (occ[h] & o==0) | (occ[0] & occ[1]). This is combinational from registers.
- `win_data` byte k = buf[(ptr+k) mod 32]. This is a combinational rotate from registers, with no gating by `win_valid`.

Per-cycle update, in priority order:
1. **flush = 1:**
   - occ <= 00, ptr <= {0, flush_off}, rel <= 00.
   - `ld_buf`, `dec_ack` and `dec_len` are ignored that cycle.
   - The next line load goes to half 0.
2. **Consume** when dec_ack & win_valid & dec_len != 0:
   - np = ptr + dec_len, 5-bit wrap mod 32.
   - If np[4] != ptr[4], half ptr[4] is drained: occ[ptr[4]] <= 0 and rel[ptr[4]] <= 1.
   - dec_len <= 15 means at most one boundary crossing per consume.
   - ptr <= np.
3. **Consume ignored** when dec_ack with win_valid = 0, or dec_len = 0: no state change, rel <= 00.
4. **Load:**
   - For each i with ld_buf[i]: buf[16i..16i+15] <= line_data, occ[i] <= 1.
   - A load into a half released in the same cycle wins: occ stays 1 and rel[i] still pulses.
   - A load into an occupied, unreleased half overwrites it. This is a protocol violation; the bench flags it and the RTL does not guard against it.
   - ld_buf = 11 loads the same line into both halves. This is legal only from IDLE after flush.
5. rel defaults to 00 every cycle unless set by rule 2.

Wrap-around:
- ptr 31 + 1 = 0, and half 1 is released.
- A window that crosses byte 31 -> 0 reads half 1 tail followed by half 0 head.

## Timing
- **Reset** (asynchronous, and mid-operation takes effect immediately): occ = 00, ptr = 0, rel = 00, buf = 0. Hence win_valid = 0 and win_data = 0.
- **Load -> window:** `ld_buf` at edge N updates occ and buf, so win_valid and win_data reflect the load in cycle N+1. No combinational path exists from ld_buf or line_data to the outputs.
- **Consume -> new window:** `dec_ack` sampled at edge N makes the new ptr and window visible after edge N. Back-to-back consumes every cycle are supported.
- **Release:** rel is high for exactly one cycle, the cycle after the consuming edge. The fetch side may assert ld_buf[i] in that same cycle.
- **Flush:** flush at edge N gives win_valid = 0 from N+1 until a line load has landed.
- No output depends combinationally on any input.

## Test plan
1. **Reset/idle.** Deassert rst_n, then release; no loads. -> occ = 00, ptr = 0, win_valid = 0, rel = 00, win_data = 0 for 10 cycles.
2. **Aligned fill and consume.**
   - Stimulus: flush with flush_off = 0; load half 0 with bytes 0x00..0x0F.
   - -> Next cycle: win_valid = 1, win_data[7:0] = 0x00.
   - Stimulus: dec_ack with dec_len = 3.
   - -> ptr = 3, win_valid = 0 because half 1 is empty.
   - Stimulus: load half 1 with 0x10..0x1F.
   - -> win_valid = 1, win_data byte 0 = 0x03, byte 15 = 0x12.
3. **Boundary release.**
   - Stimulus: from ptr = 14 with both halves occupied, dec_ack with dec_len = 5.
   - -> ptr = 19, occ = 10, rel = 01 for one cycle, then 00. win_valid = 0 until half 0 is reloaded.
4. **Wrap-around.**
   - Stimulus: ptr = 30 with both halves full; dec_ack with dec_len = 4.
   - -> ptr = 2, rel = 10, occ = 01.
   - Stimulus: refill half 1.
   - -> win_data byte 0 = buf[2].
5. **Same-cycle release and reload.**
   - Stimulus: consume crossing out of half 0 together with ld_buf = 01.
   - -> rel = 01 pulses, occ[0] stays 1, and the new bytes are visible next cycle.
6. **Flush priority.**
   - Stimulus: flush = 1 with flush_off = 9, plus simultaneous dec_ack and ld_buf = 10.
   - -> occ = 00, ptr = 9, rel = 00, and no load is performed.
   - Stimulus: then load half 0.
   - -> win_valid = 0 until half 1 is also loaded; afterwards win_data byte 0 = half 0 byte 9.
7. **Reset mid-operation.** Assert rst_n low in the cycle a consume is presented. -> All state clears at once, and no rel pulse is emitted.
